// File: rtl/ci_fir_driver.sv
// Custom-instruction driver: hands each accepted sample to a multi-cycle slave
// and presents the slave result downstream, with a bounded wait for the slave.
module ci_fir_driver #(
    parameter int unsigned TIMEOUT = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic        ci_clk_en,
    output logic        ci_start,
    output logic [31:0] ci_dataa,
    input  logic [31:0] ci_result,
    input  logic        ci_done,
    output logic        m_valid,
    output logic [31:0] m_data,
    input  logic        m_ready,
    input  logic        clr_err,
    output logic        timeout_err,
    output logic        busy,
    output logic [15:0] count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t     state;
    logic [7:0] timer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            s_ready     <= 1'b1;
            ci_clk_en   <= 1'b0;
            ci_start    <= 1'b0;
            ci_dataa    <= '0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            timeout_err <= 1'b0;
            count       <= '0;
            timer       <= '0;
            busy        <= 1'b0;
        end else begin
            // A timeout set later in this block overrides the clear.
            if (clr_err)
                timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (s_valid) begin
                        ci_dataa  <= s_data;
                        s_ready   <= 1'b0;
                        ci_start  <= 1'b1;
                        ci_clk_en <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    ci_start <= 1'b0;
                    timer    <= 8'(TIMEOUT);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (ci_done) begin
                        m_data    <= ci_result;
                        m_valid   <= 1'b1;
                        count     <= count + 16'd1;
                        ci_clk_en <= 1'b0;
                        state     <= HOLD;
                    end else begin
                        timer <= timer - 8'd1;
                        if (timer == 8'd1) begin
                            // Dropping ci_clk_en is what aborts the slave.
                            timeout_err <= 1'b1;
                            ci_clk_en   <= 1'b0;
                            s_ready     <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ci_fir_driver.sv
// Bench for ci_fir_driver: two instances (TIMEOUT 31 and 3), each with a
// latency-programmable slave model and a result scoreboard.
module tb_ci_fir_driver;

    typedef struct {
        int          k;
        logic [31:0] d;
        int          lat;
        int          hold;
        bit          exp_done;
        int          exp_exit;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid[2], s_ready[2], ci_clk_en[2], ci_start[2], ci_done[2];
    logic        m_valid[2], m_ready[2], clr_err[2], timeout_err[2], busy[2];
    logic [31:0] s_data[2], ci_dataa[2], ci_result[2], m_data[2];
    logic [15:0] count[2];
    int          lat[2];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [15:0] exp_cnt[2];
    logic        exp_err[2];
    vec_t        tbl[9];

    always #5 clk = ~clk;

    ci_fir_driver #(.TIMEOUT(31)) u_dut0 (
        .clk(clk), .reset(reset), .s_valid(s_valid[0]), .s_data(s_data[0]),
        .s_ready(s_ready[0]), .ci_clk_en(ci_clk_en[0]), .ci_start(ci_start[0]),
        .ci_dataa(ci_dataa[0]), .ci_result(ci_result[0]), .ci_done(ci_done[0]),
        .m_valid(m_valid[0]), .m_data(m_data[0]), .m_ready(m_ready[0]),
        .clr_err(clr_err[0]), .timeout_err(timeout_err[0]), .busy(busy[0]),
        .count(count[0])
    );

    ci_fir_driver #(.TIMEOUT(3)) u_dut1 (
        .clk(clk), .reset(reset), .s_valid(s_valid[1]), .s_data(s_data[1]),
        .s_ready(s_ready[1]), .ci_clk_en(ci_clk_en[1]), .ci_start(ci_start[1]),
        .ci_dataa(ci_dataa[1]), .ci_result(ci_result[1]), .ci_done(ci_done[1]),
        .m_valid(m_valid[1]), .m_data(m_data[1]), .m_ready(m_ready[1]),
        .clr_err(clr_err[1]), .timeout_err(timeout_err[1]), .busy(busy[1]),
        .count(count[1])
    );

    function automatic logic [31:0] slave_fn(input logic [31:0] d);
        return {d[15:0], d[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // Slave: done combinationally in the lat-th enabled cycle after start.
    for (genvar g = 0; g < 2; g++) begin : g_slave
        logic [7:0] scnt;
        always_ff @(posedge clk) begin
            if (ci_start[g])
                scnt <= 8'd1;
            else if (!ci_clk_en[g])
                scnt <= '0;
            else if (scnt != 8'd0)
                scnt <= scnt + 8'd1;
        end
        assign ci_done[g]   = ci_clk_en[g] && !ci_start[g] && (lat[g] != 0) && (int'(scnt) == lat[g]);
        assign ci_result[g] = slave_fn(ci_dataa[g]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input int k);
        chk("rst_s_ready", 32'(s_ready[k]), 1);
        chk("rst_ci_clk_en", 32'(ci_clk_en[k]), 0);
        chk("rst_ci_start", 32'(ci_start[k]), 0);
        chk("rst_ci_dataa", ci_dataa[k], 0);
        chk("rst_m_valid", 32'(m_valid[k]), 0);
        chk("rst_m_data", m_data[k], 0);
        chk("rst_timeout_err", 32'(timeout_err[k]), 0);
        chk("rst_count", 32'(count[k]), 0);
        chk("rst_busy", 32'(busy[k]), 0);
    endtask

    // Result scoreboard, sampled clear of both clock edges.
    always begin
        @(negedge clk);
        #1;
        if (!reset) begin
            if (m_valid[0] && m_ready[0]) begin
                chk("sb0_pending", 32'(q0.size() > 0), 1);
                if (q0.size() > 0) chk("sb0_data", m_data[0], q0.pop_front());
            end
            if (m_valid[1] && m_ready[1]) begin
                chk("sb1_pending", 32'(q1.size() > 0), 1);
                if (q1.size() > 0) chk("sb1_data", m_data[1], q1.pop_front());
            end
        end
    end

    task automatic run_txn(input vec_t v);
        int          k = v.k;
        int          mv_at = -1;
        int          starts = 0;
        int          held = 0;
        bit          exited = 0;
        logic [31:0] hd = '0;
        @(posedge clk);
        #1;
        lat[k]     = v.lat;
        m_ready[k] = (v.hold == 0);
        s_valid[k] = 1'b1;
        s_data[k]  = v.d;
        @(negedge clk);
        chk("s_ready_idle", 32'(s_ready[k]), 1);
        if (v.exp_done) begin
            if (k == 0) q0.push_back(slave_fn(v.d));
            else        q1.push_back(slave_fn(v.d));
        end
        @(posedge clk);
        #1;
        s_data[k] = ~v.d;
        for (int n = 1; n <= 80 && !exited; n++) begin
            @(negedge clk);
            if (ci_start[k]) begin
                starts++;
                if (starts == 1) chk("start_cycle", n, 1);
            end
            if (n == 2) begin
                chk("s_ready_busy", 32'(s_ready[k]), 0);
                chk("busy_high", 32'(busy[k]), 1);
                chk("dataa_held", ci_dataa[k], v.d);
                s_valid[k] = 1'b0;
            end
            if (m_valid[k]) begin
                if (mv_at < 0) begin
                    mv_at = n;
                    hd    = m_data[k];
                end
                if (held < v.hold) begin
                    chk("hold_m_valid", 32'(m_valid[k]), 1);
                    chk("hold_m_data", m_data[k], hd);
                    chk("hold_s_ready", 32'(s_ready[k]), 0);
                    chk("hold_clk_en", 32'(ci_clk_en[k]), 0);
                    held++;
                end else begin
                    m_ready[k] = 1'b1;
                end
            end
            if (n >= 2 && s_ready[k]) begin
                exited = 1;
                chk("exit_cycle", n, v.exp_exit);
            end
        end
        chk("exit_bound", 32'(exited), 1);
        if (v.exp_done) exp_cnt[k] = exp_cnt[k] + 16'd1;
        else            exp_err[k] = 1'b1;
        chk("m_valid_cycle", mv_at, v.exp_done ? v.lat + 2 : -1);
        chk("start_pulses", starts, 1);
        chk("count", 32'(count[k]), 32'(exp_cnt[k]));
        chk("timeout_err", 32'(timeout_err[k]), 32'(exp_err[k]));
        chk("idle_clk_en", 32'(ci_clk_en[k]), 0);
        chk("idle_busy", 32'(busy[k]), 0);
        m_ready[k] = 1'b1;
        s_valid[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            s_valid[k] = 1'b0;
            s_data[k]  = '0;
            m_ready[k] = 1'b1;
            clr_err[k] = 1'b0;
            lat[k]     = 0;
            exp_cnt[k] = '0;
            exp_err[k] = 1'b0;
        end
        // {instance, sample, slave latency (0 = never), HOLD stall, completes, exit cycle}
        tbl = '{
            '{0, 32'h0000_0010,  4,  0, 1'b1,  7},
            '{0, 32'hDEAD_BEEF,  1,  0, 1'b1,  4},
            '{0, 32'h1234_5678,  4, 10, 1'b1, 17},
            '{0, 32'hFFFF_FFFF, 31,  0, 1'b1, 34},
            '{0, 32'h0000_0000,  0,  0, 1'b0, 33},
            '{0, 32'h0000_A5A5,  7,  2, 1'b1, 12},
            '{1, 32'h0000_0055,  3,  0, 1'b1,  6},
            '{1, 32'h0000_0066,  0,  0, 1'b0,  5},
            '{1, 32'h0000_0077,  4,  0, 1'b0,  5}
        };

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_reset(0);
        chk_reset(1);

        for (int i = 0; i < 9; i++)
            run_txn(tbl[i]);

        @(posedge clk);
        #1;
        clr_err[1] = 1'b1;
        @(posedge clk);
        #1;
        clr_err[1] = 1'b0;
        exp_err[1] = 1'b0;
        @(negedge clk);
        chk("clr_err_clears", 32'(timeout_err[1]), 0);

        // clr_err held through a timeout: the set must win
        @(posedge clk);
        #1;
        clr_err[1] = 1'b1;
        run_txn('{1, 32'h0000_0088, 0, 0, 1'b0, 5});
        @(posedge clk);
        #1;
        clr_err[1] = 1'b0;
        exp_err[1] = 1'b0;
        @(negedge clk);
        chk("clr_after_set", 32'(timeout_err[1]), 0);

        // reset mid-WAIT aborts with no output
        @(posedge clk);
        #1;
        lat[0]     = 20;
        s_valid[0] = 1'b1;
        s_data[0]  = 32'h0000_CAFE;
        @(posedge clk);
        #1;
        s_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_wait", 32'(ci_clk_en[0]), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        exp_cnt[0] = '0;
        exp_cnt[1] = '0;
        exp_err[0] = 1'b0;
        exp_err[1] = 1'b0;
        run_txn('{0, 32'h0000_BEEF, 2, 0, 1'b1, 5});

        // counter wrap
        @(negedge clk);
        force u_dut0.count = 16'hFFFF;
        @(posedge clk);
        #1;
        release u_dut0.count;
        @(negedge clk);
        chk("count_preload", 32'(count[0]), 32'hFFFF);
        exp_cnt[0] = 16'hFFFF;
        run_txn('{0, 32'h0000_0001, 4, 0, 1'b1, 7});

        repeat (3) @(posedge clk);
        #1;
        chk("sb0_drained", q0.size(), 0);
        chk("sb1_drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ci_fir_driver.md
CI_FIR_DRIVER -- requirements
Module: ci_fir_driver

Interface
REQ-001 Parameter TIMEOUT, default 31, maximum WAIT cycles allowed for ci_done; legal range 1..255.
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 s_valid  in  1  input sample valid.
REQ-005 s_data  in  32  input sample.
REQ-006 s_ready  out  1  block accepts a sample this cycle.
REQ-007 ci_clk_en  out  1  custom-instruction clock enable to slave.
REQ-008 ci_start  out  1  custom-instruction start pulse to slave.
REQ-009 ci_dataa  out  32  operand to slave; registered.
REQ-010 ci_result  in  32  slave result.
REQ-011 ci_done  in  1  slave done, combinational with ci_clk_en at slave.
REQ-012 m_valid  out  1  output result valid.
REQ-013 m_data  out  32  output result.
REQ-014 m_ready  in  1  downstream accepts result.
REQ-015 clr_err  in  1  clears timeout_err.
REQ-016 timeout_err  out  1  sticky timeout flag.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 count  out  16  completed-transaction counter.

Function
REQ-019 The block SHALL implement states IDLE, ISSUE, WAIT, HOLD, encoded in a registered state variable.
REQ-020 IDLE: s_ready=1, ci_clk_en=0, ci_start=0; on s_valid&s_ready, s_data SHALL be registered into ci_dataa and state SHALL go to ISSUE.
REQ-021 ISSUE: exactly one cycle with ci_start=1 and ci_clk_en=1; timer loaded with TIMEOUT; next state WAIT.
REQ-022 WAIT: ci_clk_en=1, ci_start=0; ci_done SHALL be sampled only in WAIT (ci_done in ISSUE, IDLE, HOLD ignored).
REQ-023 WAIT with ci_done=1: ci_result SHALL be registered into m_data, m_valid set, count incremented, next state HOLD.
REQ-024 WAIT with ci_done=0: timer decrements by 1; when timer is 1 and ci_done=0, timeout_err SHALL be set, no result produced, count unchanged, next state IDLE.
REQ-025 ci_done and timer expiry in the same cycle SHALL resolve as completion (REQ-023), not timeout.
REQ-026 HOLD: ci_clk_en=0, s_ready=0, m_valid=1, m_data stable until m_valid&m_ready; then m_valid cleared, next state IDLE.
REQ-027 s_ready SHALL be 0 in ISSUE, WAIT, HOLD; s_valid there SHALL be ignored and s_data not sampled.
REQ-028 Latency: sample handshake at cycle T -> ci_start at T+1 -> for slave latency L (done at T+1+L) m_valid at T+2+L.
REQ-029 Throughput: with m_ready held 1, one transaction per L+3 cycles (IDLE, ISSUE, L WAIT cycles, HOLD).
REQ-030 count SHALL wrap 0xFFFF -> 0x0000 without flag.
REQ-031 timeout_err SHALL be set by REQ-024, cleared by clr_err when not being set in the same cycle; set wins over clr_err.
REQ-032 ci_clk_en low after timeout SHALL be relied on to abort the slave; no further slave drive until next sample.

Reset
REQ-033 On reset: state IDLE, ci_clk_en=0, ci_start=0, ci_dataa=0, m_valid=0, m_data=0, timeout_err=0, count=0, timer=0, busy=0.
REQ-034 Reset asserted in any state SHALL take priority over all inputs and abort the transaction with no output; s_ready=1 in first cycle after reset release.

Verification
REQ-035 Slave latency 4, s_data=0x00000010 at T, m_ready=1 -> ci_start at T+1, one pulse, m_valid at T+6 with m_data=slave result, count=1.
REQ-036 Backpressure: m_ready=0 for 10 cycles in HOLD -> m_valid and m_data stable, s_ready=0, ci_clk_en=0; m_ready=1 -> IDLE next cycle.
REQ-037 Slave never asserts done, TIMEOUT=3 -> 3 WAIT cycles, timeout_err=1, no m_valid, count unchanged; clr_err pulse -> timeout_err=0.
REQ-038 ci_done on the last WAIT cycle with TIMEOUT=3, latency 3 -> result delivered, timeout_err stays 0.
REQ-039 Reset asserted during WAIT -> next cycle all outputs at reset values; new sample completes normally.
REQ-040 count preloaded to 0xFFFF via 65535 transactions (or force) -> next completion gives count=0x0000.
